// File: rtl/axi_uart_autobaud.sv
// ---------------------------------------------------------------------------
// axi_uart_autobaud
//
// Receive-side baud-rate detector for the axi_uart_tx/axi_uart_rx pair.
// After an arm pulse it waits for an idle line, then times the five falling
// edges of a 0x55 sync character (8N1). The first-to-fifth edge distance is
// eight bit times, so the rounded result is published as clkdiv, which is the
// number of clk cycles per bit.
//
// Optional build macro:
//   AXI_UART_AUTOBAUD_GLITCH_FILTER_EN
//       Inserts a 3-sample majority filter after the synchroniser. Single-cycle
//       pulses are rejected. Every edge is delayed by one cycle, so the
//       measured intervals are unchanged.
//
// Parameters:
//   CNT_WIDTH  width of clkdiv; the interval counters are CNT_WIDTH+1 bits
//   MIN_DIV    smallest clkdiv accepted as a good result
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   arm     in   1-cycle pulse that starts or restarts a detection
//   rx      in   raw UART line, idle high, asynchronous to clk
//   clkdiv  out  detected cycles per bit, meaningful while locked=1
//   locked  out  clkdiv holds a good result
//   busy    out  detection in progress
//   error   out  last detection failed, cleared by arm
// ---------------------------------------------------------------------------
module axi_uart_autobaud #(
    parameter int CNT_WIDTH = 16,
    parameter int MIN_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 rx,
    output logic [CNT_WIDTH-1:0] clkdiv,
    output logic                 locked,
    output logic                 busy,
    output logic                 error
);

    localparam int IW = CNT_WIDTH + 1;
    localparam int TW = CNT_WIDTH + 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_START,
        MEASURE,
        STOP,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [1:0]    rx_sync;
    logic          rx_s;
    logic          line;
    logic          line_prev;
    logic          fall;

    logic [IW-1:0] cnt;
    logic [IW-1:0] t1;
    logic [TW-1:0] total;
    logic [1:0]    idx;

    logic [IW-1:0] interval;
    logic [IW-1:0] skew;
    logic          skew_bad;
    logic          cnt_sat;
    logic [TW-1:0] total_next;
    logic [TW-1:0] result;
    logic          result_bad;
    logic          fail;
    logic          lock;

    // Two-flop synchroniser. It resets to the idle level so that a reset
    // cannot produce a spurious falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s = rx_sync[1];

`ifdef AXI_UART_AUTOBAUD_GLITCH_FILTER_EN
    logic [1:0] rx_hist;

    // Keep the two previous synchronised samples for the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s};
        end
    end

    // A level change passes only after two of the three samples agree. This
    // rejects 1-cycle pulses and delays every real edge by exactly one cycle.
    assign line = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
    assign line = rx_s;
`endif

    // Previous line sample, used for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_prev <= 1'b1;
        end else begin
            line_prev <= line;
        end
    end

    assign fall = line_prev & ~line;

    // cnt restarts at zero on the cycle after an edge, so the edge-to-edge
    // distance is cnt+1 when the next edge is seen.
    assign interval   = cnt + IW'(1);
    assign skew       = (interval >= t1) ? (interval - t1) : (t1 - interval);
    assign skew_bad   = skew > (t1 >> 2);
    assign cnt_sat    = &cnt;
    assign total_next = total + {{(TW-IW){1'b0}}, interval};
    assign result     = (total + TW'(4)) >> 3;
    assign result_bad = (result < TW'(MIN_DIV)) || (|result[TW-1:CNT_WIDTH]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A failure in any state sends the FSM to IDLE. arm is
    // evaluated last so that it overrides both a failure and a lock.
    always_comb begin
        next_state = state;
        fail       = 1'b0;
        lock       = 1'b0;
        case (state)
            IDLE: begin
            end
            WAIT_IDLE: begin
                if (line) next_state = WAIT_START;
            end
            WAIT_START: begin
                if (fall) next_state = MEASURE;
            end
            MEASURE: begin
                if (cnt_sat) begin
                    fail = 1'b1;
                end else if (fall) begin
                    if ((idx != 2'd0) && skew_bad) begin
                        fail = 1'b1;
                    end else if (idx == 2'd3) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (line) begin
                    next_state = DONE;
                end else if (cnt >= t1) begin
                    fail = 1'b1;
                end
            end
            DONE: begin
                if (result_bad) begin
                    fail = 1'b1;
                end else begin
                    lock       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (fail) next_state = IDLE;
        if (arm) begin
            next_state = WAIT_IDLE;
            fail       = 1'b0;
            lock       = 1'b0;
        end
    end

    // Interval datapath. idx counts the completed intervals. After T4 it wraps
    // to 0, and STOP reuses cnt as its timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            t1    <= '0;
            total <= '0;
            idx   <= '0;
        end else begin
            case (state)
                WAIT_START: begin
                    cnt   <= '0;
                    total <= '0;
                    idx   <= '0;
                end
                MEASURE: begin
                    if (fall) begin
                        cnt   <= '0;
                        total <= total_next;
                        idx   <= idx + 2'd1;
                        if (idx == 2'd0) t1 <= interval;
                    end else begin
                        cnt <= cnt + IW'(1);
                    end
                end
                STOP: begin
                    cnt <= cnt + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers. clkdiv keeps its last value across an arm. It is only
    // meaningful while locked is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv <= '0;
            locked <= 1'b0;
            error  <= 1'b0;
        end else if (arm) begin
            locked <= 1'b0;
            error  <= 1'b0;
        end else if (fail) begin
            locked <= 1'b0;
            error  <= 1'b1;
        end else if (lock) begin
            locked <= 1'b1;
            clkdiv <= result[CNT_WIDTH-1:0];
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_axi_uart_autobaud.sv
`timescale 1ns/1ps
// Testbench for axi_uart_autobaud. The clock is 4 MHz. CNT_WIDTH=8 is used so
// that counter saturation is reached quickly.
module tb_axi_uart_autobaud;

    localparam int W       = 8;
    localparam int MIN_DIV = 4;
    localparam int SAT     = 1 << (W + 1);

`ifdef AXI_UART_AUTOBAUD_GLITCH_FILTER_EN
    localparam int LOCK_LAT = 5;
`else
    localparam int LOCK_LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         arm;
    logic         rx;
    logic [W-1:0] clkdiv;
    logic         locked;
    logic         busy;
    logic         error;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   falls[$];
    int   rises[$];
    logic lastRx = 1'b1;
    int   stopRiseCyc = 0;
    int   lockRiseCyc = -1;
    logic lockedPrev = 1'b0;
    bit   expErr;
    int   expDiv;

    axi_uart_autobaud #(.CNT_WIDTH(W), .MIN_DIV(MIN_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arm    (arm),
        .rx     (rx),
        .clkdiv (clkdiv),
        .locked (locked),
        .busy   (busy),
        .error  (error)
    );

    always #125 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle on which locked rises, for the latency check.
    always @(negedge clk) begin
        if (locked === 1'b1 && lockedPrev !== 1'b1) lockRiseCyc = cyc;
        lockedPrev = locked;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive rx and log the edge times that the reference model uses.
    task automatic driveRx(input logic v);
        if (lastRx === 1'b1 && v === 1'b0) falls.push_back(cyc);
        if (lastRx === 1'b0 && v === 1'b1) rises.push_back(cyc);
        rx     = v;
        lastRx = v;
    endtask

    // Arm the detector, then send one 8N1 frame. Each edge after the start
    // edge may move by jitter (-1..+1 cycle). The bit-4 edge can be shifted by
    // warp cycles. glitchBit (if high) receives a 1-cycle low pulse mid-bit.
    task automatic applyStimulus(input logic [7:0] data, input int div, input bit jitter,
                                 input int glitchBit, input int warp);
        int         pos[11];
        logic [9:0] bits;
        int         dur;
        falls.delete();
        rises.delete();
        bits   = {1'b1, data, 1'b0};
        pos[0] = 0;
        for (int k = 1; k < 10; k++)
            pos[k] = k * div + (jitter ? int'($urandom_range(0, 2)) - 1 : 0) + ((k == 4) ? warp : 0);
        pos[10] = 10 * div;
        arm = 1'b1;
        waitCycles(1);
        arm = 1'b0;
        waitCycles(3);
        for (int k = 0; k < 10; k++) begin
            dur = pos[k+1] - pos[k];
            driveRx(bits[k]);
            if (k == 9) stopRiseCyc = cyc;
            if (k == glitchBit && bits[k] == 1'b1) begin
                waitCycles(dur / 2);
`ifdef AXI_UART_AUTOBAUD_GLITCH_FILTER_EN
                rx = 1'b0;
                waitCycles(1);
                rx = 1'b1;
`else
                driveRx(1'b0);
                waitCycles(1);
                driveRx(1'b1);
`endif
                waitCycles(dur - dur / 2 - 1);
            end else begin
                waitCycles(dur);
            end
        end
    endtask

    // Reference model. Works from the logged line edges and the detection rules.
    task automatic computeExpected();
        int t[4];
        int d;
        int r;
        expErr = 1'b0;
        expDiv = 0;
        if (falls.size() < 5) begin
            expErr = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                t[i] = falls[i+1] - falls[i];
                if (t[i] >= SAT) expErr = 1'b1;
            end
            for (int i = 1; i < 4; i++) begin
                d = t[i] - t[0];
                if (d < 0) d = -d;
                if (d > t[0] / 4) expErr = 1'b1;
            end
            r = -1;
            foreach (rises[i]) if (r < 0 && rises[i] > falls[4]) r = rises[i];
            if (r < 0 || (r - falls[4]) > t[0]) expErr = 1'b1;
            expDiv = (falls[4] - falls[0] + 4) / 8;
            if (expDiv < MIN_DIV || expDiv > (1 << W) - 1) expErr = 1'b1;
        end
    endtask

    // Wait (with a bound) until detection ends, then compare with the model.
    task automatic checkResult(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            waitCycles(1);
            n++;
        end
        computeExpected();
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_error"}, error, expErr);
        checkOutput({tag, "_locked"}, locked, !expErr);
        if (!expErr) checkOutput({tag, "_clkdiv"}, clkdiv, expDiv);
        waitCycles(10);
    endtask

    initial begin
        int div;
        rst_n = 1'b0;
        arm   = 1'b0;
        rx    = 1'b1;
        waitCycles(3);
        checkOutput("reset_clkdiv", clkdiv, 0);
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_error", error, 0);
        rst_n = 1'b1;
        waitCycles(5);

        $display("[TB] test 1: 0x55 at 32 clk/bit");
        applyStimulus(8'h55, 32, 1'b0, -1, 0);
        checkResult("t1");
        checkOutput("t1_clkdiv32", clkdiv, 32);
        checkOutput("t1_latency", lockRiseCyc - stopRiseCyc, LOCK_LAT);

        $display("[TB] test 2: 0x55 at 16 clk/bit with jitter");
        applyStimulus(8'h55, 16, 1'b1, -1, 0);
        checkResult("t2");
        checkOutput("t2_clkdiv16", clkdiv, 16);

        $display("[TB] test 3: 0x00 saturates");
        applyStimulus(8'h00, 32, 1'b0, -1, 0);
        checkResult("t3");
        checkOutput("t3_error", error, 1);

        $display("[TB] test 4: glitch mid bit 3");
        applyStimulus(8'h55, 32, 1'b0, 3, 0);
        checkResult("t4");

        $display("[TB] test 5: reset during measure");
        arm = 1'b1;
        waitCycles(1);
        arm = 1'b0;
        waitCycles(3);
        driveRx(1'b0);
        waitCycles(32);
        driveRx(1'b1);
        waitCycles(32);
        driveRx(1'b0);
        waitCycles(16);
        checkOutput("t5_busy_before", busy, 1);
        rst_n = 1'b0;
        waitCycles(2);
        checkOutput("t5_rst_clkdiv", clkdiv, 0);
        checkOutput("t5_rst_locked", locked, 0);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_error", error, 0);
        rst_n = 1'b1;
        driveRx(1'b1);
        waitCycles(40);
        applyStimulus(8'h55, 32, 1'b0, -1, 0);
        checkResult("t5");
        checkOutput("t5_clkdiv32", clkdiv, 32);

        $display("[TB] test 6: 3 clk/bit below MIN_DIV, then recover");
        applyStimulus(8'h55, 3, 1'b0, -1, 0);
        checkResult("t6a");
        checkOutput("t6a_error", error, 1);
        applyStimulus(8'h55, 32, 1'b0, -1, 0);
        checkResult("t6b");
        checkOutput("t6b_clkdiv32", clkdiv, 32);
        checkOutput("t6b_latency", lockRiseCyc - stopRiseCyc, LOCK_LAT);

        $display("[TB] random trials");
        for (int n = 0; n < 12; n++) begin
            div = int'($urandom_range(8, 60));
            applyStimulus(8'h55, div, bit'($urandom_range(0, 1)), -1,
                          ($urandom_range(0, 3) == 0) ? div / 2 : 0);
            checkResult($sformatf("rnd%0d_div%0d", n, div));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
